// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver slice.
// FSM encodings stay as sized constants for compatibility with existing netlists.
package uart_pkg;
   typedef logic [1:0] state_t;

   localparam state_t IDLE  = 2'd0;
   localparam state_t START = 2'd1;
   localparam state_t DATA  = 2'd2;
   localparam state_t STOP  = 2'd3;

   localparam logic [7:0] ASCII_FIRST = 8'd97;
   localparam logic [7:0] ASCII_LAST  = 8'd122;
endpackage

// File: rtl/ascii_seq_check.sv
// Checks that received words follow the sequence 'a'..'z' (wrapping).
// Registered so seq_err lines up with the registered valid pulse of the receiver.
module ascii_seq_check
   import uart_pkg::*;
#(
   parameter int SIZE = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic [SIZE-1:0] data,
   output logic            seq_err
);
   localparam logic [SIZE-1:0] FIRST = SIZE'(ASCII_FIRST);
   localparam logic [SIZE-1:0] LAST  = SIZE'(ASCII_LAST);

   logic [SIZE-1:0] expected;
   logic [SIZE-1:0] succ;

   // Match and mismatch share one rule: the next expected is data's successor.
   always_comb begin
      succ = FIRST;
      if (data >= FIRST && data < LAST)
         succ = data + SIZE'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         expected <= FIRST;
         seq_err  <= 1'b0;
      end else begin
         seq_err <= load && (data != expected);
         if (load)
            expected <= succ;
      end
   end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and stop-bit framing check.
// Define ASCII_CHECK_EN to add the 'a'..'z' sequence checker driving seq_err.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 12000000,
   parameter int BAUD     = 115200,
   parameter int SIZE     = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            rx,
   output logic [SIZE-1:0] word,
   output logic            valid,
   output logic            busy,
   output logic            frame_err,
   output logic            seq_err
);
   localparam int DIV  = CLK_FREQ / BAUD;
   localparam int HALF = DIV / 2;
   localparam int CW   = $clog2(DIV);
   localparam int BW   = (SIZE > 1) ? $clog2(SIZE) : 1;

   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(SIZE - 1);

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [BW-1:0]   bitidx;
   logic [SIZE-1:0] shreg;
   logic            s1, s2, s3;

   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         s1        <= 1'b1;
         s2        <= 1'b1;
         s3        <= 1'b1;
         state     <= IDLE;
         cnt       <= '0;
         bitidx    <= '0;
         shreg     <= '0;
         word      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         s1        <= rx;
         s2        <= s1;
         s3        <= s2;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            // Edge-triggered start: a line stuck low never re-arms a frame.
            IDLE: begin
               if (s3 && !s2) begin
                  state <= START;
                  cnt   <= '0;
               end
            end
            START: begin
               if (cnt == CNT_HALF) begin
                  cnt    <= '0;
                  bitidx <= '0;
                  state  <= s2 ? IDLE : DATA;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DATA: begin
               if (cnt == CNT_LAST) begin
                  cnt    <= '0;
                  shreg  <= {s2, shreg[SIZE-1:1]};
                  bitidx <= bitidx + BW'(1);
                  if (bitidx == BIT_LAST)
                     state <= STOP;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            STOP: begin
               if (cnt == CNT_LAST) begin
                  cnt   <= '0;
                  state <= IDLE;
                  if (s2) begin
                     word  <= shreg;
                     valid <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ASCII_CHECK_EN
   logic load;
   assign load = (state == STOP) && (cnt == CNT_LAST) && s2;

   ascii_seq_check #(.SIZE(SIZE)) u_check (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .data    (shreg),
      .seq_err (seq_err)
   );
`else
   assign seq_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at DIV=10; expectations follow ASCII_CHECK_EN.
`timescale 1ns/1ps
module tb_uart_rx;
   localparam int DIV = 10;
`ifdef ASCII_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   typedef struct {
      bit         fe;
      logic [7:0] w;
      bit         seq;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic [7:0] word;
   logic       valid, busy, frame_err, seq_err;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   uart_rx #(.CLK_FREQ(1000000), .BAUD(100000), .SIZE(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .word      (word),
      .valid     (valid),
      .busy      (busy),
      .frame_err (frame_err),
      .seq_err   (seq_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops one expectation for every valid or frame_err pulse.
   always @(negedge clk) begin
      if (!rst) begin
         if (valid || frame_err) begin
            chk("exclusive", {31'd0, valid & frame_err}, 32'd0);
            if (q.size() == 0) begin
               chk("unexpected_out", {30'd0, valid, frame_err}, 32'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("frame_err", {31'd0, frame_err}, {31'd0, e.fe});
               if (valid) begin
                  chk("word", {24'd0, word}, {24'd0, e.w});
                  chk("seq_err", {31'd0, seq_err}, {31'd0, e.seq});
               end
            end
         end else if (seq_err) begin
            chk("stray_seq_err", {31'd0, seq_err}, 32'd0);
         end
      end
   end

   task automatic hold(input logic v, input int n);
      rx = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop, input bit exp_seq);
      exp_t e;
      e.fe  = !stop;
      e.w   = b;
      e.seq = stop ? (exp_seq & CHK) : 1'b0;
      q.push_back(e);
      hold(1'b0, DIV);
      chk("busy_in_frame", {31'd0, busy}, 32'd1);
      for (int i = 0; i < 8; i++)
         hold(b[i], DIV);
      hold(stop, DIV);
      if (stop)
         hold(1'b1, DIV);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      rx  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_word", {24'd0, word}, 32'd0);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
      chk("rst_seq_err", {31'd0, seq_err}, 32'd0);
      rst = 1'b0;
      hold(1'b1, 5);
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && q.size() != 0; i++)
         @(posedge clk);
      #1;
      chk("drain", q.size(), 32'd0);
      q.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] ch;

      // Basic a,b,c.
      do_reset();
      send_frame(8'h61, 1'b1, 1'b0);
      send_frame(8'h62, 1'b1, 1'b0);
      send_frame(8'h63, 1'b1, 1'b0);
      drain();

      // Full alphabet followed by the wrap back to 'a'.
      do_reset();
      for (int i = 0; i < 26; i++) begin
         ch = 8'h61 + 8'(i);
         send_frame(ch, 1'b1, 1'b0);
      end
      send_frame(8'h61, 1'b1, 1'b0);
      drain();

      // Frame error with line left low, then recovery.
      do_reset();
      send_frame(8'h61, 1'b1, 1'b0);
      send_frame(8'h61, 1'b0, 1'b0);
      hold(1'b0, 3 * DIV);
      chk("low_line_idle", {31'd0, busy}, 32'd0);
      chk("word_after_fe", {24'd0, word}, 32'h61);
      hold(1'b1, 2 * DIV);
      send_frame(8'h62, 1'b1, 1'b0);
      drain();

      // Three-cycle glitch must be rejected in START.
      hold(1'b0, 3);
      chk("glitch_start", {31'd0, busy}, 32'd1);
      hold(1'b1, 12);
      chk("glitch_idle", {31'd0, busy}, 32'd0);
      drain();

      // Sequence violation and resync.
      do_reset();
      send_frame(8'h61, 1'b1, 1'b0);
      send_frame(8'h63, 1'b1, 1'b1);
      send_frame(8'h64, 1'b1, 1'b0);
      drain();
      chk("word_before_abort", {24'd0, word}, 32'h64);

      // Reset during data bit 4 aborts silently.
      ch = 8'h55;
      hold(1'b0, DIV);
      for (int i = 0; i < 4; i++)
         hold(ch[i], DIV);
      hold(ch[4], 5);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_word", {24'd0, word}, 32'd0);
      chk("abort_valid", {31'd0, valid}, 32'd0);
      rst = 1'b0;
      hold(1'b1, 2 * DIV);
      send_frame(8'h7A, 1'b1, 1'b1);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 12000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, serial bit rate.
REQ-003 SHALL have parameter SIZE, default 8, data word width.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous to clk and active-high.
REQ-006 SHALL have port rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-007 SHALL have port word  output  SIZE  last correctly framed received byte.
REQ-008 SHALL have port valid  output  1  one-cycle pulse when word is updated.
REQ-009 SHALL have port busy  output  1  high while a frame is being received.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-011 SHALL have port seq_err  output  1  one-cycle pulse on an a..z sequence violation (see Configuration).

Function
REQ-012 SHALL compute DIV = CLK_FREQ/BAUD (integer truncation) and HALF = DIV/2; default values 104 and 52.
REQ-013 SHALL pass rx through a 2-flop synchronizer before use; both flops reset to 1.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP with a baud counter of width clog2(DIV).
REQ-015 IDLE: SHALL enter START and clear the counter only on a synced 1->0 transition; a line held low SHALL NOT start a frame.
REQ-016 START: at count HALF-1, SHALL enter DATA if synced rx=0 (counter cleared), else return to IDLE (glitch reject).
REQ-017 DATA: every DIV cycles SHALL shift in one bit, LSB first; after SIZE bits SHALL enter STOP.
REQ-018 STOP: after DIV cycles SHALL sample rx; 1 -> load word, pulse valid the next cycle; 0 -> pulse frame_err, word unchanged; then IDLE.
REQ-019 valid and frame_err SHALL never be high in the same cycle and SHALL be exactly one cycle wide.
REQ-020 busy SHALL be high in START, DATA and STOP, and low in IDLE.
REQ-021 After a frame error with rx still low, a new frame SHALL start only after rx returns high and falls again.

Reset
REQ-022 On rst: state IDLE, counter 0, word 0, valid 0, busy 0, frame_err 0, seq_err 0, synchronizer 1, expected 97.
REQ-023 rst asserted mid-frame SHALL abort it with no valid or frame_err pulse; reception restarts on the next falling edge.

Configuration
REQ-024 Macro ASCII_CHECK_EN defined: SHALL check each valid byte against an expected register, initialised to 97 ('a').
REQ-025 With ASCII_CHECK_EN, a match SHALL advance expected (122 wraps to 97) with no error.
REQ-026 With ASCII_CHECK_EN, a mismatch SHALL pulse seq_err in the same cycle as valid.
REQ-027 With ASCII_CHECK_EN, after a mismatch expected SHALL resync to the successor of word if word is in 97..122, else to 97.
REQ-028 Macro ASCII_CHECK_EN undefined: seq_err SHALL be tied to 0 and no checker logic SHALL be synthesized.

Structure
REQ-029 Package uart_pkg SHALL hold the FSM state typedef and constants ASCII_FIRST=8'd97 and ASCII_LAST=8'd122.
REQ-030 The checker SHALL be a sub-module ascii_seq_check, instantiated only under ASCII_CHECK_EN.

Verification (CLK_FREQ=1000000, BAUD=100000 -> DIV=10)
REQ-031 After reset, frames 0x61,0x62,0x63 sent -> three valid pulses with word 0x61,0x62,0x63; frame_err=0, seq_err=0.
REQ-032 Frames 'a'..'z' then 'a' sent -> 27 valid pulses, seq_err never asserted (wrap 122->97 accepted).
REQ-033 Frame 0x61 with stop bit 0 -> frame_err pulse, no valid, word holds its prior value; the next frame 0x62 after rx is high is received.
REQ-034 rx low for 3 cycles then high -> no busy beyond START, no valid, FSM back in IDLE.
REQ-035 With ASCII_CHECK_EN, 0x61 then 0x63 sent -> seq_err pulse with the 0x63 valid pulse; a following 0x64 gives no seq_err.
REQ-036 rst asserted during DATA bit 4 -> busy=0 the next cycle, no valid pulse; a subsequent 0x7A frame is received correctly.
